// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles the regfile write-port arbitration signals: the MEM/WB pipeline
//   write request, the multi-cycle unit result handshake, the regfile write
//   port and the stall request to the hazard unit.
//   master : drives WB_* and mc_valid/mc_result/mc_rd_addr, observes the rest
//   slave  : the arbiter; drives mc_ready, stall_o and rf_*
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if;
  logic [31:0] WB_result;
  logic [4:0]  WB_rd_addr;
  logic        WB_wen;
  logic        mc_valid;
  logic        mc_ready;
  logic [31:0] mc_result;
  logic [4:0]  mc_rd_addr;
  logic        stall_o;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  WB_result, WB_rd_addr, WB_wen,
    input  mc_valid, mc_result, mc_rd_addr,
    output mc_ready, stall_o,
    output rf_wen, rf_waddr, rf_wdata
  );

  modport master (
    output WB_result, WB_rd_addr, WB_wen,
    output mc_valid, mc_result, mc_rd_addr,
    input  mc_ready, stall_o,
    input  rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the MEM/WB pipeline
//   and a multi-cycle unit. Multi-cycle results are queued in a DEPTH-entry
//   FIFO; the pipeline has priority, and when the FIFO head has waited
//   STARVE_MAX cycles the block stalls the pipeline (stall_o) and drains.
// Ports
//   clk          clock, all state on rising edge
//   rstn         synchronous reset, active low
//   bus          wb_port_arbiter_if.slave (WB_*, mc_*, rf_*, stall_o)
//   conflict_cnt (only with WBARB_PERF_EN) saturating count of cycles in
//                which the FIFO is non-empty and the pipeline slot is used
// Configuration macro: WBARB_PERF_EN
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rstn,
`ifdef WBARB_PERF_EN
  output logic [31:0]        conflict_cnt,
`endif
  wb_port_arbiter_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [4:0]      mem_addr_q [DEPTH];
  logic [31:0]     mem_data_q [DEPTH];

  logic full, empty, slot_used, push, pop, grant_fifo;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign slot_used = bus.WB_wen && (bus.WB_rd_addr != 5'd0);

  assign bus.mc_ready = rstn && !full;
  // x0 results are acknowledged but never stored, so they cost no slot
  assign push = bus.mc_valid && bus.mc_ready && (bus.mc_rd_addr != 5'd0);

  // Next-state / grant decode
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    pop        = 1'b0;
    grant_fifo = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) state_d = PEND;
      end
      PEND: begin
        if (slot_used) begin
          starve_d = starve_q + 1'b1;
          // this cycle is the STARVE_MAX-th ungranted one
          if (starve_q >= SW'(STARVE_MAX - 1)) state_d = FORCE;
        end else begin
          pop        = 1'b1;
          grant_fifo = 1'b1;
          starve_d   = '0;
          if (count_q == CW'(1) && !push) state_d = IDLE;
        end
      end
      FORCE: begin
        pop        = 1'b1;
        grant_fifo = 1'b1;
        if (count_q == CW'(1) && !push) begin
          state_d  = IDLE;
          starve_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port mux: the write lands at the same edge as the grant
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (rstn) begin
      if (grant_fifo) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = mem_addr_q[rd_ptr_q];
        bus.rf_wdata = mem_data_q[rd_ptr_q];
      end else if (slot_used) begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = bus.WB_rd_addr;
        bus.rf_wdata = bus.WB_result;
      end
    end
  end

  assign bus.stall_o = rstn && (state_q == FORCE);

  // Control state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= bus.mc_rd_addr;
      mem_data_q[wr_ptr_q] <= bus.mc_result;
    end
  end

`ifdef WBARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      conflict_cnt <= '0;
    end else if (!empty && slot_used && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
